// File: rtl/bus_timer_pkg.sv
// Shared register map, bit indices and decode helper for the bus_timer slice.
// Optional capture support is selected by TIMER_CAPTURE_EN in bus_timer.sv.
package bus_timer_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_F100;

    localparam logic [4:0] TMR_CTRL     = 5'h00;
    localparam logic [4:0] TMR_LOAD     = 5'h04;
    localparam logic [4:0] TMR_COUNT    = 5'h08;
    localparam logic [4:0] TMR_STATUS   = 5'h0C;
    localparam logic [4:0] TMR_PRESCALE = 5'h10;
    localparam logic [4:0] TMR_CAPTURE  = 5'h14;

    localparam int unsigned CTRL_EN          = 0;
    localparam int unsigned CTRL_AUTO_RELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN      = 2;
    localparam int unsigned CTRL_CAP_IRQ_EN  = 3;

    localparam int unsigned STAT_EXPIRED  = 0;
    localparam int unsigned STAT_CAPTURED = 1;

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_LOAD,
        SEL_COUNT,
        SEL_STATUS,
        SEL_PRESCALE,
        SEL_CAPTURE,
        SEL_RSVD
    } reg_sel_e;

    // Word-aligned decode; the byte-lane bits of the offset are ignored.
    function automatic reg_sel_e decode_sel(input logic [4:0] off);
        case ({off[4:2], 2'b00})
            TMR_CTRL:     return SEL_CTRL;
            TMR_LOAD:     return SEL_LOAD;
            TMR_COUNT:    return SEL_COUNT;
            TMR_STATUS:   return SEL_STATUS;
            TMR_PRESCALE: return SEL_PRESCALE;
            TMR_CAPTURE:  return SEL_CAPTURE;
            default:      return SEL_RSVD;
        endcase
    endfunction

endpackage

// File: rtl/bus_timer_if.sv
// CPU data-bus connection between the bridge (master) and the timer (slave).
interface bus_timer_if;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_hit;

    modport master (
        output bus_addr, bus_we, bus_wdata,
        input  bus_rdata, bus_hit
    );

    modport slave (
        input  bus_addr, bus_we, bus_wdata,
        output bus_rdata, bus_hit
    );
endinterface

// File: rtl/bus_timer_prescaler.sv
// Prescaler for bus_timer: counts 0..prescale while enabled, tick on the last count.
module timer_prescaler #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] prescale,
    output logic         tick
);
    logic [W-1:0] pre_cnt_q, pre_cnt_d;

    assign tick = en & (pre_cnt_q == prescale);

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (clr || !en || tick) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end
endmodule

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer with prescaler, auto-reload and sticky expiry irq.
// Define TIMER_CAPTURE_EN to add the capture_in input, CAPTURE register and CAP_IRQ_EN.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic         cpu_clk,
    input  logic         cpu_rst_n,
    bus_timer_if.slave   bus,
    output logic         irq
`ifdef TIMER_CAPTURE_EN
    ,
    input  logic         capture_in
`endif
);
    logic                  en_q, en_d;
    logic                  auto_q, auto_d;
    logic                  irq_en_q, irq_en_d;
    logic [31:0]           load_q, load_d;
    logic [31:0]           count_q, count_d;
    logic                  expired_q, expired_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;

    logic        hit, wr, tick, pre_clr;
    reg_sel_e    sel;
    logic [31:0] rdata;
    logic        unused_addr_bits;

`ifdef TIMER_CAPTURE_EN
    logic        cap_s1_q, cap_s2_q, cap_prev_q, cap_edge;
    logic        cap_irq_en_q, cap_irq_en_d;
    logic        captured_q, captured_d;
    logic [31:0] capture_q, capture_d;

    assign cap_edge = cap_s2_q & ~cap_prev_q;
`endif

    assign unused_addr_bits = ^bus.bus_addr[1:0];

    assign hit = (bus.bus_addr[31:5] == BASE_ADDR[31:5]);
    assign sel = decode_sel(bus.bus_addr[4:0]);
    assign wr  = hit & bus.bus_we;

    // Restart the prescale phase when the timer is (re)started or its period changes.
    assign pre_clr = wr && ((sel == SEL_PRESCALE) ||
                            (sel == SEL_CTRL && bus.bus_wdata[CTRL_EN] && !en_q));

    timer_prescaler #(.W(PRESCALE_W)) u_prescaler (
        .clk      (cpu_clk),
        .rst_n    (cpu_rst_n),
        .en       (en_q),
        .clr      (pre_clr),
        .prescale (prescale_q),
        .tick     (tick)
    );

    // Tick effects are applied first so bus writes override them; expiry set lands last.
    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        irq_en_d   = irq_en_q;
        load_d     = load_q;
        count_d    = count_q;
        expired_d  = expired_q;
        prescale_d = prescale_q;
`ifdef TIMER_CAPTURE_EN
        cap_irq_en_d = cap_irq_en_q;
        captured_d   = captured_q;
        capture_d    = capture_q;
`endif
        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - 32'd1;
            end else if (auto_q) begin
                count_d = load_q;
            end else begin
                en_d = 1'b0;
            end
        end

        if (wr) begin
            case (sel)
                SEL_CTRL: begin
                    en_d     = bus.bus_wdata[CTRL_EN];
                    auto_d   = bus.bus_wdata[CTRL_AUTO_RELOAD];
                    irq_en_d = bus.bus_wdata[CTRL_IRQ_EN];
`ifdef TIMER_CAPTURE_EN
                    cap_irq_en_d = bus.bus_wdata[CTRL_CAP_IRQ_EN];
`endif
                end
                SEL_LOAD:     load_d  = bus.bus_wdata;
                SEL_COUNT:    count_d = bus.bus_wdata;
                SEL_STATUS: begin
                    expired_d = expired_q & ~bus.bus_wdata[STAT_EXPIRED];
`ifdef TIMER_CAPTURE_EN
                    captured_d = captured_q & ~bus.bus_wdata[STAT_CAPTURED];
`endif
                end
                SEL_PRESCALE: prescale_d = bus.bus_wdata[PRESCALE_W-1:0];
                default: ;
            endcase
        end

        if (tick && (count_q == '0)) begin
            expired_d = 1'b1;
        end
`ifdef TIMER_CAPTURE_EN
        if (cap_edge) begin
            capture_d  = count_q;
            captured_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            load_q     <= '0;
            count_q    <= '0;
            expired_q  <= 1'b0;
            prescale_q <= '0;
`ifdef TIMER_CAPTURE_EN
            cap_s1_q     <= 1'b0;
            cap_s2_q     <= 1'b0;
            cap_prev_q   <= 1'b0;
            cap_irq_en_q <= 1'b0;
            captured_q   <= 1'b0;
            capture_q    <= '0;
`endif
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            load_q     <= load_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
            prescale_q <= prescale_d;
`ifdef TIMER_CAPTURE_EN
            cap_s1_q     <= capture_in;
            cap_s2_q     <= cap_s1_q;
            cap_prev_q   <= cap_s2_q;
            cap_irq_en_q <= cap_irq_en_d;
            captured_q   <= captured_d;
            capture_q    <= capture_d;
`endif
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (sel)
                SEL_CTRL: begin
                    rdata[CTRL_EN]          = en_q;
                    rdata[CTRL_AUTO_RELOAD] = auto_q;
                    rdata[CTRL_IRQ_EN]      = irq_en_q;
`ifdef TIMER_CAPTURE_EN
                    rdata[CTRL_CAP_IRQ_EN]  = cap_irq_en_q;
`endif
                end
                SEL_LOAD:     rdata = load_q;
                SEL_COUNT:    rdata = count_q;
                SEL_STATUS: begin
                    rdata[STAT_EXPIRED]  = expired_q;
`ifdef TIMER_CAPTURE_EN
                    rdata[STAT_CAPTURED] = captured_q;
`endif
                end
                SEL_PRESCALE: rdata = 32'(prescale_q);
`ifdef TIMER_CAPTURE_EN
                SEL_CAPTURE:  rdata = capture_q;
`endif
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.bus_rdata = rdata;
    assign bus.bus_hit   = hit;

`ifdef TIMER_CAPTURE_EN
    assign irq = (expired_q & irq_en_q) | (captured_q & cap_irq_en_q);
`else
    assign irq = expired_q & irq_en_q;
`endif
endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped countdown timer on the CPU data bus. It is the responder side of the Bus_addr/Bus_we/Bus_wdata/Bus_rdata interface and is instantiated behind the bridge.
- The CPU is single-cycle, so reads return in the same cycle and are combinational from the registers. Writes commit on the rising edge.
- Byte and half stores reach this block as full-word read-modify-write data, so only word writes are defined.

Parameters:
- BASE_ADDR, 32'hFFFF_F100, base of the 32-byte register window; bits [4:0] must be 0.
- PRESCALE_W, 16, width of the PRESCALE register and the prescaler counter.

Ports:
- cpu_clk  in  1  system clock.
- cpu_rst_n  in  1  asynchronous active-low reset.
- bus_addr  in  32  byte address from the bridge.
- bus_we  in  1  write strobe; qualified by hit.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, combinational.
- bus_hit  out  1  high when bus_addr[31:5] == BASE_ADDR[31:5].
- irq  out  1  level interrupt request.

Behaviour:
- Register map (offset, word access, bus_addr[1:0] ignored):
  - 0x00 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN; other bits read 0.
  - 0x04 LOAD: 32-bit reload value.
  - 0x08 COUNT: read returns the current count; a write loads the count directly.
  - 0x0C STATUS: [0] EXPIRED, sticky; writing 1 clears it, writing 0 has no effect.
  - 0x10 PRESCALE: [PRESCALE_W-1:0]; upper bits read 0.
  - 0x14–0x1C: reserved; reads return 0, writes are ignored.
- Reads: bus_rdata is the selected register when hit, else 0. Zero added latency.
- Writes: commit at the cpu_clk edge when hit & bus_we.
- Reset: all registers are 0 (EN=0, LOAD=0, COUNT=0, EXPIRED=0, PRESCALE=0), prescaler counter is 0, irq=0, bus_rdata follows the zeroed registers.
- Prescaler:
  - pre_cnt counts 0..PRESCALE and wraps to 0 while EN=1.
  - tick is high for one cycle when EN=1 and pre_cnt==PRESCALE.
  - PRESCALE=0 gives a tick every cycle.
  - pre_cnt holds at 0 while EN=0.
  - pre_cnt is forced to 0 on any CTRL write that sets EN from 0 to 1, and on any PRESCALE write.
- Counter, evaluated on tick:
  - COUNT != 0: COUNT <= COUNT-1.
  - COUNT == 0: EXPIRED <= 1. If AUTO_RELOAD=1, COUNT <= LOAD; otherwise EN <= 0 (one-shot stop, COUNT stays 0).
  - Auto-reload period = (LOAD+1)*(PRESCALE+1) cycles.
- irq = EXPIRED & IRQ_EN, driven from flops with no combinational path from bus inputs.
- Simultaneous events:
  - COUNT write in the same cycle as tick: the write wins.
  - STATUS clear in the same cycle as an expiry set: the set wins, EXPIRED=1.
  - CTRL write in the same cycle as a one-shot auto-clear of EN: the written EN wins.
- Reset asserted mid-count: all state returns to reset values immediately, with no pending tick.

Optional Feature:
- Macro TIMER_CAPTURE_EN.
- When defined:
  - Adds input capture_in (1 bit, asynchronous), synchronised by two flops.
  - A synchronised rising edge copies COUNT into CAPTURE at offset 0x14 and sets STATUS[1] CAPTURED (sticky, write-1-clear).
  - CTRL[3] CAP_IRQ_EN is added, and irq becomes (EXPIRED&IRQ_EN)|(CAPTURED&CAP_IRQ_EN).
  - A capture edge coinciding with a COUNT write captures the pre-write value.
- When undefined: no capture_in port, 0x14 reads 0, STATUS[1] and CTRL[3] read 0, irq as above.

Decomposition:
- Shared package/defines header holds:
  - register offsets (TMR_CTRL, TMR_LOAD, TMR_COUNT, TMR_STATUS, TMR_PRESCALE, TMR_CAPTURE);
  - CTRL/STATUS bit indices;
  - default BASE_ADDR.
- One sub-module, timer_prescaler: inputs clk, rst_n, en, clr, prescale; output tick.

Test Plan:
1. Reset then read 0x00–0x1C: every read returns 0, irq=0, bus_hit=1 only inside BASE_ADDR..BASE_ADDR+0x1F.
2. PRESCALE=0, LOAD=3, COUNT=3, CTRL=0x7: COUNT reads 3,2,1,0,3 on successive cycles. EXPIRED and irq rise on the cycle COUNT reloads to 3, and the period is 4 cycles.
3. PRESCALE=2, COUNT=1, CTRL=0x1 (one-shot): COUNT decrements every 3 cycles. After expiry CTRL reads 0, COUNT holds 0, EXPIRED=1, irq=0 because IRQ_EN=0.
4. Write STATUS=1 in the same cycle as an expiry tick: EXPIRED reads 1. A STATUS=1 write on a later non-expiry cycle: EXPIRED reads 0 and irq drops.
5. Write COUNT=0x10 on a tick cycle: COUNT reads 0x10, not 0x0F. Assert cpu_rst_n low mid-count: all registers read 0 immediately.
6. With TIMER_CAPTURE_EN, LOAD=100, running at PRESCALE=0: pulse capture_in. CAPTURE equals COUNT sampled 2 cycles after the edge (±0), and STATUS reads 0x2 (0x3 if expired).
